// File: rtl/fixed_broadcast_pkg.sv
// ============================================================================
// Module   : fixed_broadcast_pkg
// Brief    : Shared types and the word-extension helper for fixed_broadcast_fork.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package fixed_broadcast_pkg;

   // Widest word/lane count any instantiating module may request.
   localparam int MAX_WIDTH = 128;
   localparam int MAX_LANES = 64;

   typedef logic [MAX_WIDTH-1:0] word_t;
   typedef logic [MAX_LANES-1:0] lane_mask_t;

   // Extends an in_width-bit value held in the low bits of 'in' to the full word.
   function automatic word_t extend_word(input word_t in, input int unsigned in_width,
                                         input logic signed_en);
      word_t ones;
      word_t fill_mask;
      logic  msb;
      ones      = '1;
      fill_mask = ones << in_width;
      msb       = |(in & (word_t'(1) << (in_width - 1)));
      return (signed_en && msb) ? (in | fill_mask) : (in & ~fill_mask);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_broadcast_pending_mask.sv
// ============================================================================
// Module   : fixed_broadcast_pending_mask
// Brief    : Per-lane pending mask; derives lane valids, fires and the drain flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fixed_broadcast_pending_mask
   import fixed_broadcast_pkg::*;
#(
   parameter int OUT_SIZE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                buf_full,
   input  logic [OUT_SIZE-1:0] lane_ready,
   output logic [OUT_SIZE-1:0] lane_valid,
   output logic                drain
);

   logic [OUT_SIZE-1:0] pending;
   logic [OUT_SIZE-1:0] fire;

   assign lane_valid = {OUT_SIZE{buf_full}} & pending;
   assign fire       = lane_valid & lane_ready;
   // Drain when no lane would remain pending after this cycle's fires.
   assign drain      = buf_full & ((pending & ~fire) == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
      end else if (load) begin
         pending <= '1;
      end else if (drain) begin
         pending <= '0;
      end else begin
         pending <= pending & ~fire;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fixed_broadcast_fork.sv
// ============================================================================
// Module   : fixed_broadcast_fork
// Brief    : Broadcasts one width-extended word to OUT_SIZE handshaked lanes.
//            Define FIXED_BROADCAST_SIGN_EXT_EN for sign- instead of zero-extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fixed_broadcast_fork
   import fixed_broadcast_pkg::*;
#(
   parameter int OUT_SIZE  = 4,
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = IN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic [OUT_WIDTH-1:0] data_out [OUT_SIZE-1:0],
   output logic [OUT_SIZE-1:0]  data_out_valid,
   input  logic [OUT_SIZE-1:0]  data_out_ready
);

`ifdef FIXED_BROADCAST_SIGN_EXT_EN
   localparam logic SIGN_EXT = 1'b1;
`else
   localparam logic SIGN_EXT = 1'b0;
`endif

   word_t                ext_full;
   logic                 unused_ext;
   logic [OUT_WIDTH-1:0] buf_data;
   logic                 buf_full;
   logic                 drain;
   logic                 load;

   assign ext_full      = extend_word(word_t'(data_in), IN_WIDTH, SIGN_EXT);
   assign unused_ext    = ^ext_full;
   assign data_in_ready = ~buf_full | drain;
   assign load          = data_in_valid & data_in_ready;

   fixed_broadcast_pending_mask #(
      .OUT_SIZE (OUT_SIZE)
   ) u_pending (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .buf_full   (buf_full),
      .lane_ready (data_out_ready),
      .lane_valid (data_out_valid),
      .drain      (drain)
   );

   // A load wins over a drain so back-to-back words stream at full rate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_full <= 1'b0;
         buf_data <= '0;
      end else if (load) begin
         buf_full <= 1'b1;
         buf_data <= ext_full[OUT_WIDTH-1:0];
      end else if (drain) begin
         buf_full <= 1'b0;
      end
   end

   generate
      for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lanes
         assign data_out[j] = buf_data;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fixed_broadcast_fork.sv
// ============================================================================
// Module   : tb_fixed_broadcast_fork
// Brief    : Self-checking bench for fixed_broadcast_fork (4-lane and 1-lane builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fixed_broadcast_fork;

   localparam int NL = 4;
   localparam int IW = 8;
   localparam int OW = 10;
`ifdef FIXED_BROADCAST_SIGN_EXT_EN
   localparam bit SIGN = 1'b1;
`else
   localparam bit SIGN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   logic [IW-1:0] din4 = '0;
   logic          din_v4 = 1'b0;
   logic          rin4;
   logic [OW-1:0] dout4 [NL-1:0];
   logic [NL-1:0] vout4;
   logic [NL-1:0] rdy4;
   logic [NL-1:0] rdy4_drv = '0;
   logic [NL-1:0] fb_mask = '0;
   logic          fb_mode = 1'b0;

   logic [IW-1:0] din1 = '0;
   logic          din_v1 = 1'b0;
   logic          rin1;
   logic [OW-1:0] dout1 [0:0];
   logic [0:0]    vout1;
   logic [0:0]    rdy1 = '0;

   int passed = 0;
   int total  = 0;

   // Scoreboard: words each lane still owes its consumer, oldest first.
   logic [OW-1:0] lane_q [NL][$];
   logic [OW-1:0] q1 [$];

   assign rdy4 = fb_mode ? (vout4 & fb_mask) : rdy4_drv;

   always #5 clk = ~clk;

   fixed_broadcast_fork #(.OUT_SIZE(NL), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut4 (
      .clk(clk), .rst(rst), .data_in(din4), .data_in_valid(din_v4),
      .data_in_ready(rin4), .data_out(dout4), .data_out_valid(vout4),
      .data_out_ready(rdy4));

   fixed_broadcast_fork #(.OUT_SIZE(1), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut1 (
      .clk(clk), .rst(rst), .data_in(din1), .data_in_valid(din_v1),
      .data_in_ready(rin1), .data_out(dout1), .data_out_valid(vout1),
      .data_out_ready(rdy1));

   function automatic logic [OW-1:0] ext(input logic [IW-1:0] w);
      if (SIGN) return {{(OW-IW){w[IW-1]}}, w};
      return {{(OW-IW){1'b0}}, w};
   endfunction

   // Input is free to enter once every lane has either nothing owed or takes it now.
   function automatic logic exp_rin4();
      for (int j = 0; j < NL; j++)
         if (lane_q[j].size() != 0 && !rdy4[j]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NL-1:0] exp_vout4();
      logic [NL-1:0] v;
      for (int j = 0; j < NL; j++) v[j] = (lane_q[j].size() != 0);
      return v;
   endfunction

   // Called at the negedge: commits this cycle's transfers to the model over the edge.
   task automatic advance4(output bit acc);
      logic [NL-1:0] f;
      logic [IW-1:0] w;
      bit a;
      a = din_v4 && exp_rin4();
      w = din4;
      for (int j = 0; j < NL; j++) f[j] = (lane_q[j].size() != 0) && rdy4[j];
      @(posedge clk);
      for (int j = 0; j < NL; j++) if (f[j]) void'(lane_q[j].pop_front());
      if (a) for (int j = 0; j < NL; j++) lane_q[j].push_back(ext(w));
      acc = a;
      #1;
   endtask

   task automatic idle4(input int n);
      bit acc;
      din_v4 = 1'b0; rdy4_drv = '1;
      repeat (n) begin @(negedge clk); advance4(acc); end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (vout4 !== 4'b0000) $display("FAIL reset_valid4 got=%b exp=0000", vout4); else passed++;
      total++; if (rin4 !== 1'b1) $display("FAIL reset_ready4 got=%b exp=1", rin4); else passed++;
      total++; if (dout4[0] !== '0 || dout4[3] !== '0) $display("FAIL reset_data4 got=%h/%h exp=000", dout4[0], dout4[3]); else passed++;
      total++; if (vout1 !== 1'b0 || rin1 !== 1'b1) $display("FAIL reset_dut1 got v=%b r=%b exp v=0 r=1", vout1, rin1); else passed++;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      logic [IW-1:0] words [3];
      logic [OW-1:0] exp_tbl [3];
      bit acc;
      words = '{8'h05, 8'h80, 8'hFF};
      if (SIGN) exp_tbl = '{10'h005, 10'h380, 10'h3FF};
      else      exp_tbl = '{10'h005, 10'h080, 10'h0FF};
      rdy4_drv = '1;
      for (int k = 0; k < 5; k++) begin
         din_v4 = (k < 3);
         if (k < 3) din4 = words[k];
         @(negedge clk);
         total++; if (rin4 !== 1'b1) $display("FAIL stream_ready c%0d got=%b exp=1", k, rin4); else passed++;
         total++; if (vout4 !== exp_vout4()) $display("FAIL stream_valid c%0d got=%b exp=%b", k, vout4, exp_vout4()); else passed++;
         if (k >= 1 && k <= 3)
            for (int j = 0; j < NL; j++) begin
               total++;
               if (dout4[j] !== exp_tbl[k-1]) $display("FAIL stream_data c%0d lane%0d got=%h exp=%h", k, j, dout4[j], exp_tbl[k-1]);
               else passed++;
            end
         advance4(acc);
      end
   endtask

   task automatic test_lane_stall();
      bit acc;
      bit sent22 = 0;
      din4 = 8'h11; din_v4 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         rdy4_drv = (k < 5) ? 4'b1011 : 4'b1111;
         @(negedge clk);
         total++; if (rin4 !== exp_rin4()) $display("FAIL stall_ready c%0d got=%b exp=%b", k, rin4, exp_rin4()); else passed++;
         total++; if (vout4 !== exp_vout4()) $display("FAIL stall_valid c%0d got=%b exp=%b", k, vout4, exp_vout4()); else passed++;
         for (int j = 0; j < NL; j++)
            if (lane_q[j].size() != 0) begin
               total++;
               if (dout4[j] !== lane_q[j][0]) $display("FAIL stall_data c%0d lane%0d got=%h exp=%h", k, j, dout4[j], lane_q[j][0]);
               else passed++;
            end
         if (k >= 2 && k <= 4) begin
            total++; if (rin4 !== 1'b0 || vout4 !== 4'b0100) $display("FAIL stall_hold c%0d got r=%b v=%b exp r=0 v=0100", k, rin4, vout4); else passed++;
         end
         if (k == 5) begin
            total++; if (rin4 !== 1'b1) $display("FAIL stall_release got=%b exp=1", rin4); else passed++;
         end
         advance4(acc);
         if (acc) begin
            if (sent22) din_v4 = 1'b0;
            din4 = 8'h22; sent22 = 1;
         end
      end
      idle4(2);
   endtask

   task automatic test_staggered();
      bit acc;
      din4 = 8'h44; din_v4 = 1'b1; rdy4_drv = '0;
      @(negedge clk); advance4(acc);
      din4 = 8'h55;
      for (int k = 0; k < 4; k++) begin
         rdy4_drv = 4'(1 << k);
         @(negedge clk);
         total++; if (rin4 !== (k == 3)) $display("FAIL stagger_ready c%0d got=%b exp=%b", k, rin4, (k == 3)); else passed++;
         total++; if (vout4 !== exp_vout4()) $display("FAIL stagger_valid c%0d got=%b exp=%b", k, vout4, exp_vout4()); else passed++;
         total++; if (dout4[k] !== ext(8'h44)) $display("FAIL stagger_data lane%0d got=%h exp=%h", k, dout4[k], ext(8'h44)); else passed++;
         advance4(acc);
      end
      idle4(2);
   endtask

   task automatic test_reset_mid_word();
      bit acc;
      din4 = 8'h33; din_v4 = 1'b1; rdy4_drv = '0;
      @(negedge clk); advance4(acc);
      din_v4 = 1'b0; rdy4_drv = 4'b0011;
      @(negedge clk); advance4(acc);
      rdy4_drv = '0;
      @(negedge clk);
      total++; if (vout4 !== 4'b1100) $display("FAIL midrst_partial got=%b exp=1100", vout4); else passed++;
      #2 rst = 1'b0;
      #1;
      total++; if (vout4 !== 4'b0000) $display("FAIL midrst_async_valid got=%b exp=0000", vout4); else passed++;
      total++; if (rin4 !== 1'b1) $display("FAIL midrst_async_ready got=%b exp=1", rin4); else passed++;
      for (int j = 0; j < NL; j++) lane_q[j].delete();
      q1.delete();
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      rdy4_drv = '1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++; if (vout4 !== 4'b0000) $display("FAIL midrst_after_valid c%0d got=%b exp=0000", k, vout4); else passed++;
         total++; if (rin4 !== 1'b1) $display("FAIL midrst_after_ready c%0d got=%b exp=1", k, rin4); else passed++;
         advance4(acc);
      end
   endtask

   task automatic test_feedback_ready();
      bit acc;
      fb_mode = 1'b1; din_v4 = 1'b1; din4 = 8'($urandom);
      for (int k = 0; k < 40; k++) begin
         fb_mask = 4'($urandom);
         @(negedge clk);
         total++; if (rin4 !== exp_rin4()) $display("FAIL fb_ready c%0d got=%b exp=%b", k, rin4, exp_rin4()); else passed++;
         total++; if (vout4 !== exp_vout4()) $display("FAIL fb_valid c%0d got=%b exp=%b", k, vout4, exp_vout4()); else passed++;
         for (int j = 0; j < NL; j++)
            if (lane_q[j].size() != 0) begin
               total++;
               if (dout4[j] !== lane_q[j][0]) $display("FAIL fb_data c%0d lane%0d got=%h exp=%h", k, j, dout4[j], lane_q[j][0]);
               else passed++;
            end
         advance4(acc);
         if (acc) din4 = 8'($urandom);
      end
      fb_mode = 1'b0;
      idle4(2);
   endtask

   task automatic test_single_lane_random();
      bit a, f;
      logic [IW-1:0] w;
      for (int k = 0; k < 1000; k++) begin
         din_v1 = 1'($urandom); din1 = 8'($urandom); rdy1 = 1'($urandom);
         @(negedge clk);
         total++; if (vout1[0] !== (q1.size() != 0)) $display("FAIL single_valid c%0d got=%b exp=%b", k, vout1[0], (q1.size() != 0)); else passed++;
         if (q1.size() != 0) begin
            total++; if (dout1[0] !== q1[0]) $display("FAIL single_data c%0d got=%h exp=%h", k, dout1[0], q1[0]); else passed++;
         end
         total++; if (rin1 !== (q1.size() == 0 || rdy1[0])) $display("FAIL single_ready c%0d got=%b exp=%b", k, rin1, (q1.size() == 0 || rdy1[0])); else passed++;
         f = (q1.size() != 0) && rdy1[0];
         a = din_v1 && (q1.size() == 0 || rdy1[0]);
         w = din1;
         @(posedge clk);
         if (f) void'(q1.pop_front());
         if (a) q1.push_back(ext(w));
         #1;
      end
      din_v1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_lane_stall();
      test_staggered();
      test_reset_mid_word();
      test_feedback_ready();
      test_single_lane_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
